// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the sequential control unit.
//   - opcode encodings and their 23-bit control words
//   - NOP_WORD driven whenever no live instruction is on the bus
//   - FSM state type, counter width
//   - is_multicycle(): opcodes that occupy the stage for several cycles
package ctrl_pkg;

  localparam int unsigned CTRL_OPC_W = 7;
  localparam int unsigned CTRL_SIG_W = 23;
  localparam int unsigned CNT_W      = 4;

  localparam logic [CTRL_OPC_W-1:0] OPC_ADDI  = 7'b0010001;
  localparam logic [CTRL_OPC_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [CTRL_OPC_W-1:0] OPC_ALU   = 7'b0011001;
  localparam logic [CTRL_OPC_W-1:0] OPC_ALUX  = 7'b0011000;
  localparam logic [CTRL_OPC_W-1:0] OPC_BR    = 7'b1100001;
  localparam logic [CTRL_OPC_W-1:0] OPC_MUL   = 7'b1101000;
  localparam logic [CTRL_OPC_W-1:0] OPC_JAL   = 7'b1100010;

  localparam logic [CTRL_SIG_W-1:0] WORD_ADDI = 23'b01110100000101001100011;
  localparam logic [CTRL_SIG_W-1:0] WORD_LOAD = 23'b01110101000100001100011;
  localparam logic [CTRL_SIG_W-1:0] WORD_ALU  = 23'b01100100000101011100011;
  localparam logic [CTRL_SIG_W-1:0] WORD_ALUX = 23'b01111100000101011100011;
  localparam logic [CTRL_SIG_W-1:0] WORD_BR   = 23'b00000000000001110000000;
  localparam logic [CTRL_SIG_W-1:0] WORD_MUL  = 23'b01100100000001110100000;
  localparam logic [CTRL_SIG_W-1:0] WORD_JAL  = 23'b01100100000000011100010;

  localparam logic [CTRL_SIG_W-1:0] NOP_WORD  = 23'b0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MC   = 1'b1
  } ctrl_state_e;

  // Opcodes that hold the stage for more than one cycle.
  function automatic logic is_multicycle(input logic [CTRL_OPC_W-1:0] opc);
    case (opc)
      OPC_LOAD, OPC_MUL: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode lookup.
// Ports:
//   opcode_i     in  OPC_W       opcode from decode
//   word_o       out CTRL_SIG_W  control word (NOP_WORD when not legal)
//   legal_o      out 1           opcode is in the table
//   multicycle_o out 1           legal opcode that occupies several cycles
// Opcodes wider than the table width are legal only if their extra MSBs are 0.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 7
) (
  input  logic [OPC_W-1:0]      opcode_i,
  output logic [CTRL_SIG_W-1:0] word_o,
  output logic                  legal_o,
  output logic                  multicycle_o
);

  logic [CTRL_OPC_W-1:0] opc_s;
  logic                  hi_zero_s;
  logic                  hit_s;

  if (OPC_W > CTRL_OPC_W) begin : g_wide
    assign opc_s     = opcode_i[CTRL_OPC_W-1:0];
    assign hi_zero_s = (opcode_i[OPC_W-1:CTRL_OPC_W] == '0);
  end else begin : g_narrow
    assign opc_s     = CTRL_OPC_W'(opcode_i);
    assign hi_zero_s = 1'b1;
  end

  // Table lookup; unknown encodings fall through to NOP and not-legal.
  always_comb begin
    word_o = NOP_WORD;
    hit_s  = 1'b1;
    case (opc_s)
      OPC_ADDI: word_o = WORD_ADDI;
      OPC_LOAD: word_o = WORD_LOAD;
      OPC_ALU:  word_o = WORD_ALU;
      OPC_ALUX: word_o = WORD_ALUX;
      OPC_BR:   word_o = WORD_BR;
      OPC_MUL:  word_o = WORD_MUL;
      OPC_JAL:  word_o = WORD_JAL;
      default: begin
        word_o = NOP_WORD;
        hit_s  = 1'b0;
      end
    endcase
  end

  assign legal_o      = hit_s && hi_zero_s;
  assign multicycle_o = legal_o && is_multicycle(opc_s);

endmodule

// File: rtl/ctrl_unit_seq.sv
// ctrl_unit_seq: handshaked, registered opcode -> control-word stage.
// Ports:
//   clk           in  1      rising-edge clock
//   reset         in  1      synchronous active-low reset
//   opcode        in  OPC_W  opcode from decode
//   opcode_valid  in  1      opcode presented this cycle
//   op_ready      out 1      stage accepts an opcode (!busy && !stall)
//   stall         in  1      downstream hold, freezes all state
//   flush         in  1      kill current/in-flight opcode (beats stall)
//   signals       out SIG_W  registered control word
//   signals_valid out 1      signals carries a live word
//   busy          out 1      multi-cycle opcode not yet in its final cycle
//   illegal       out 1      one-cycle pulse for an accepted unknown opcode
module ctrl_unit_seq #(
  parameter int unsigned      OPC_W     = 7,
  parameter int unsigned      SIG_W     = 23,
  parameter int unsigned      MC_CYCLES = 2,
  parameter logic [SIG_W-1:0] NOP_WORD  = SIG_W'(ctrl_pkg::NOP_WORD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             opcode_valid,
  output logic             op_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [SIG_W-1:0] signals,
  output logic             signals_valid,
  output logic             busy,
  output logic             illegal
);
  import ctrl_pkg::*;

  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 1);

  ctrl_state_e           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [SIG_W-1:0]      signals_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  illegal_q;

  logic [CTRL_SIG_W-1:0] dec_word_s;
  logic                  dec_legal_s;
  logic                  dec_mc_s;
  logic                  op_ready_s;
  logic                  accept_s;

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode_i     (opcode),
    .word_o       (dec_word_s),
    .legal_o      (dec_legal_s),
    .multicycle_o (dec_mc_s)
  );

  // busy_q is low during the final MC cycle, so a new opcode can issue then.
  assign op_ready_s = !busy_q && !stall;
  assign accept_s   = opcode_valid && op_ready_s;

  // Control FSM: reset > flush > stall > normal sequencing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      signals_q <= NOP_WORD;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      signals_q <= NOP_WORD;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        ST_MC: begin
          // Word stays held; leave MC when the last busy cycle ends.
          illegal_q <= 1'b0;
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_MC;
            busy_q  <= 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_IDLE: begin
          cnt_q <= '0;
          if (accept_s && !dec_legal_s) begin
            state_q   <= ST_IDLE;
            signals_q <= NOP_WORD;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b1;
          end else if (accept_s) begin
            signals_q <= SIG_W'(dec_word_s);
            valid_q   <= 1'b1;
            illegal_q <= 1'b0;
            if (dec_mc_s) begin
              state_q <= ST_MC;
              busy_q  <= 1'b1;
              cnt_q   <= MC_LOAD;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            state_q   <= ST_IDLE;
            signals_q <= NOP_WORD;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          signals_q <= NOP_WORD;
          valid_q   <= 1'b0;
          busy_q    <= 1'b0;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready      = op_ready_s;
  assign signals       = signals_q;
  assign signals_valid = valid_q;
  assign busy          = busy_q;
  assign illegal       = illegal_q;

endmodule
